// File: rtl/adc_collector_pkg.sv
// Shared widths and result bundle for the ADC sample collector.
package adc_collector_pkg;
  localparam int DATA_W     = 12;
  localparam int CH_W       = 5;
  localparam int NUM_CH_DEF = 17;

  typedef struct packed {
    logic [CH_W-1:0]   channel;
    logic [DATA_W-1:0] data;
  } avg_result_t;
endpackage

// File: rtl/adc_result_fifo.sv
// Result FIFO: registered storage, extra pointer bit separates full from empty.
module adc_result_fifo
  import adc_collector_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  avg_result_t din,
  output avg_result_t dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  avg_result_t   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          rd_en;
  logic          wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A full FIFO still takes a push when the head leaves at the same edge
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/adc_sample_collector.sv
// Per-channel 2^AVG_LOG2 sample averager feeding a result FIFO,
// plus a latest-raw-sample readback.
module adc_sample_collector
  import adc_collector_pkg::*;
#(
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CH     = NUM_CH_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              resp_valid,
  input  logic              resp_startofpacket,
  input  logic              resp_endofpacket,
  input  logic              resp_empty,
  input  logic [CH_W-1:0]   resp_channel,
  input  logic [DATA_W-1:0] resp_data,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic [CH_W-1:0]   avg_channel,
  output logic [DATA_W-1:0] avg_data,
  input  logic [CH_W-1:0]   rd_channel,
  output logic [DATA_W-1:0] rd_data,
  output logic              overflow,
  input  logic              clear_overflow
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc    [NUM_CH];
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [DATA_W-1:0] latest [NUM_CH];

  logic        accept;
  logic        complete;
  logic [ACC_W-1:0] sum;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        drop;
  avg_result_t din;
  avg_result_t dout;
  logic        unused_pkt;

  assign unused_pkt = ^{resp_startofpacket, resp_endofpacket, resp_empty};

  assign accept   = resp_valid && (32'(resp_channel) < NUM_CH);
  assign sum      = acc[resp_channel] + ACC_W'(resp_data);
  // With AVG_LOG2=0 the count stays 0 == CNT_LAST, so every beat completes
  assign complete = (cnt[resp_channel] == CNT_LAST);
  assign push     = accept && complete;
  assign pop      = avg_valid && avg_ready;
  assign drop     = push && full && !pop;

  assign din.channel = resp_channel;
  assign din.data    = DATA_W'(sum >> AVG_LOG2);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]    <= '0;
        cnt[i]    <= '0;
        latest[i] <= '0;
      end
    end else if (accept) begin
      latest[resp_channel] <= resp_data;
      if (complete) begin
        acc[resp_channel] <= '0;
        cnt[resp_channel] <= '0;
      end else begin
        acc[resp_channel] <= sum;
        cnt[resp_channel] <= cnt[resp_channel] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      rd_data <= (32'(rd_channel) < NUM_CH) ? latest[rd_channel] : '0;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  adc_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  assign avg_valid   = !empty;
  assign avg_channel = dout.channel;
  assign avg_data    = dout.data;
endmodule

// File: doc/adc_sample_collector.md
ADC_SAMPLE_COLLECTOR -- requirements
Module: adc_sample_collector

Interface
REQ-001 The block SHALL have parameter AVG_LOG2, default 2, log2 of samples averaged per channel (range 0..4).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, result FIFO entries (power of 2, >=2).
REQ-003 The block SHALL have parameter NUM_CH, default 17, number of tracked ADC channels (0..NUM_CH-1).
REQ-004 The block SHALL have port clk_clk  in  1  sole clock; all logic rising-edge.
REQ-005 The block SHALL have port reset_reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port resp_valid  in  1  ADC response beat valid (no backpressure exists).
REQ-007 The block SHALL have ports resp_startofpacket  in  1, resp_endofpacket  in  1 and resp_empty  in  1, all accepted and ignored.
REQ-008 The block SHALL have port resp_channel  in  5  sample channel number.
REQ-009 The block SHALL have port resp_data  in  12  unsigned sample.
REQ-010 The block SHALL have port avg_valid  out  1  averaged result available.
REQ-011 The block SHALL have port avg_ready  in  1  downstream accepts result.
REQ-012 The block SHALL have port avg_channel  out  5  channel of head result.
REQ-013 The block SHALL have port avg_data  out  12  averaged value of head result.
REQ-014 The block SHALL have port rd_channel  in  5  latest-sample read select.
REQ-015 The block SHALL have port rd_data  out  12  latest raw sample of rd_channel, registered.
REQ-016 The block SHALL have port overflow  out  1  sticky result-drop flag.
REQ-017 The block SHALL have port clear_overflow  in  1  clears overflow.

Function
REQ-018 A beat SHALL be accepted when resp_valid=1 and resp_channel<NUM_CH; beats with resp_channel>=NUM_CH SHALL have no effect.
REQ-019 On acceptance, latest[ch] SHALL be written with resp_data at that clock edge.
REQ-020 Each channel SHALL hold an accumulator of 12+AVG_LOG2 bits and a count of AVG_LOG2 bits; the sum SHALL never overflow.
REQ-021 A non-completing beat (count < 2^AVG_LOG2-1) SHALL add resp_data to acc[ch] and increment count[ch].
REQ-022 A completing beat SHALL form (acc[ch]+resp_data)>>AVG_LOG2 (truncating), push {ch, result} to the FIFO at the same edge, and clear acc[ch] and count[ch] to 0.
REQ-023 With AVG_LOG2=0, every accepted beat SHALL be completing (pass-through).
REQ-024 avg_valid SHALL be 1 in the cycle after a push into an empty FIFO (1-cycle latency); avg_channel/avg_data SHALL show the FIFO head combinationally from registers.
REQ-025 A pop SHALL occur when avg_valid=1 and avg_ready=1; avg_channel/avg_data SHALL stay stable while avg_valid=1 and avg_ready=0.
REQ-026 When the FIFO is full and a push occurs without a same-cycle pop, the result SHALL be dropped, overflow SHALL set, and acc/count SHALL still clear.
REQ-027 When the FIFO is full and a push and a pop coincide, both SHALL take effect and no drop SHALL occur.
REQ-028 When the FIFO is empty, a push and avg_ready SHALL NOT bypass; the result SHALL appear the next cycle.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-030 clear_overflow SHALL clear overflow next edge; a simultaneous drop SHALL take priority (overflow stays 1).
REQ-031 rd_data SHALL equal latest[rd_channel] one cycle after sampling rd_channel; rd_channel>=NUM_CH SHALL return 0.

Reset
REQ-032 While reset_reset=1, all acc, count, latest and FIFO pointers SHALL be 0, and avg_valid, avg_channel, avg_data, rd_data and overflow SHALL be 0.
REQ-033 Assertion mid-average SHALL discard partial sums; the first post-reset completion SHALL require a full 2^AVG_LOG2 new beats.

Structure
REQ-034 Package adc_collector_pkg SHALL hold DATA_W=12, CH_W=5, the default NUM_CH and the result struct {channel, data}.
REQ-035 The FIFO SHALL be one sub-module, adc_result_fifo (sync, registered storage, push/pop/full/empty).

Verification
REQ-036 Averaging (AVG_LOG2=2): ch3 beats 100,101,102,104 -> one result ch3/101, avg_valid rises 1 cycle after the 4th beat.
REQ-037 Interleave: ch0 4x4095 alternating with ch16 4x0 -> results ch0/4095 then ch16/0 in order; ch20 beats ignored.
REQ-038 Overflow (FIFO_DEPTH=8, avg_ready=0): 9 completions -> 8 held, 9th dropped, overflow=1; clear_overflow -> overflow=0.
REQ-039 Full plus simultaneous push and pop: no drop, count stays 8, order preserved.
REQ-040 Reset after 2 beats on ch5 -> post-reset beats 8,8,8,8 yield ch5/8; rd_channel=5 -> rd_data=8.
